// File: rtl/sr_cmd_driver.sv
// SR flop command stage: debounce, edge capture, arbitration, pulse shaping.
// Optional SR_CMD_DROP_CNT_EN adds an 8-bit saturating drop counter port.
module sr_cmd_driver #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int PULSE_LEN = 1,
  parameter bit PRIO_SET  = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       set_in,
  input  logic       rst_in,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic       q_model
`ifdef SR_CMD_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE_S,
    DRIVE_R,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [2:0]       PL_MAX  = 3'(PULSE_LEN - 1);

  // index 0 = set path, index 1 = reset path
  logic [1:0]       w_raw;
  logic [1:0]       r_db;
  logic [1:0]       r_db_q;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       w_rise;

  logic   r_pend_set;
  logic   r_pend_rst;
  state_t r_state;
  state_t w_next;
  logic [2:0] r_pcnt;
  logic [2:0] w_pcnt_nxt;
  logic   w_take_set;
  logic   w_take_rst;
  logic   w_conf;

  assign w_raw  = {rst_in, set_in};
  assign w_rise = r_db & ~r_db_q;

  // Debounce both raw lines; r_db_q delays the level for edge detection
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_db     <= '0;
      r_db_q   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_db_q <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (w_raw[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // One pending slot per request type; a fresh edge survives consumption
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pend_set <= 1'b0;
      r_pend_rst <= 1'b0;
    end else begin
      r_pend_set <= w_rise[0] | (r_pend_set & ~w_take_set);
      r_pend_rst <= w_rise[1] | (r_pend_rst & ~w_take_rst);
    end
  end

  // Next-state logic: arbitration in IDLE, pulse timing in DRIVE
  always_comb begin
    w_next     = r_state;
    w_pcnt_nxt = r_pcnt;
    w_take_set = 1'b0;
    w_take_rst = 1'b0;
    w_conf     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pcnt_nxt = '0;
        if (r_pend_set && r_pend_rst) begin
          w_take_set = 1'b1;
          w_take_rst = 1'b1;
          w_conf     = 1'b1;
          w_next     = PRIO_SET ? DRIVE_S : DRIVE_R;
        end else if (r_pend_set) begin
          w_take_set = 1'b1;
          w_next     = DRIVE_S;
        end else if (r_pend_rst) begin
          w_take_rst = 1'b1;
          w_next     = DRIVE_R;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (r_pcnt == PL_MAX) begin
          w_next = GAP;
        end else begin
          w_pcnt_nxt = r_pcnt + 3'd1;
        end
      end
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= IDLE;
      r_pcnt   <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pcnt   <= w_pcnt_nxt;
      s        <= (w_next == DRIVE_S);
      r        <= (w_next == DRIVE_R);
      busy     <= (w_next != IDLE);
      conflict <= w_conf;
    end
  end

  // Shadow of the downstream flop sampling s/r one edge later
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_model <= 1'b0;
    end else if (s) begin
      q_model <= 1'b1;
    end else if (r) begin
      q_model <= 1'b0;
    end
  end

`ifdef SR_CMD_DROP_CNT_EN
  logic       w_dup_set;
  logic       w_dup_rst;
  logic [1:0] w_drop_inc;
  logic [8:0] w_drop_sum;
  logic [7:0] r_drop;

  assign w_dup_set  = w_rise[0] & r_pend_set & ~w_take_set;
  assign w_dup_rst  = w_rise[1] & r_pend_rst & ~w_take_rst;
  assign w_drop_inc = {1'b0, w_dup_set} + {1'b0, w_dup_rst}
                    + {1'b0, w_conf};
  assign w_drop_sum = {1'b0, r_drop} + {7'b0, w_drop_inc};
  assign drop_cnt   = r_drop;

  // Saturating count of dropped duplicate edges and lost arbitrations
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_drop <= '0;
    end else begin
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: vector table plus reset corner cases.
// Second instance uses PULSE_LEN=4 for the mid-pulse reset sequence.
module tb_sr_cmd_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, set_in, rst_in;
  logic s, r, busy, conflict, q_model;
  logic clr2, set2, rst2;
  logic s2, r2, busy2, conf2, q2;
`ifdef SR_CMD_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  sr_cmd_driver dut (
    .clk(clk), .clr(clr), .set_in(set_in), .rst_in(rst_in),
    .s(s), .r(r), .busy(busy), .conflict(conflict),
    .q_model(q_model)
`ifdef SR_CMD_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  sr_cmd_driver #(.PULSE_LEN(4)) dut2 (
    .clk(clk), .clr(clr2), .set_in(set2), .rst_in(rst2),
    .s(s2), .r(r2), .busy(busy2), .conflict(conf2),
    .q_model(q2)
`ifdef SR_CMD_DROP_CNT_EN
    , .drop_cnt(drop_cnt2)
`endif
  );

  // s and r must never be high together on either instance
  always @(negedge clk) begin
    checks++;
    if ((s & r) || (s2 & r2)) begin
      errors++;
      $display("FAIL excl t=%0t s=%b r=%b s2=%b r2=%b want s&r=0",
               $time, s, r, s2, r2);
    end
  end

  typedef struct {
    logic       si;
    logic       ri;
    logic [4:0] exp;  // {s, r, busy, conflict, q_model}
  } vec_t;

  vec_t tbl [41];

  task automatic fill(input int a, input int b, input logic si,
                      input logic ri, input logic [4:0] e);
    for (int k = a; k <= b; k++) begin
      tbl[k-1].si  = si;
      tbl[k-1].ri  = ri;
      tbl[k-1].exp = e;
    end
  endtask

  task automatic chk(input string nm, input logic [4:0] got,
                     input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  initial begin
    // set command
    fill(1, 5, 1'b1, 1'b0, 5'b00000);
    fill(6, 6, 1'b1, 1'b0, 5'b10100);
    fill(7, 7, 1'b1, 1'b0, 5'b00101);
    fill(8, 8, 1'b1, 1'b0, 5'b00001);
    fill(9, 12, 1'b0, 1'b0, 5'b00001);
    // 3-edge glitch on rst_in
    fill(13, 15, 1'b0, 1'b1, 5'b00001);
    fill(16, 18, 1'b0, 1'b0, 5'b00001);
    // simultaneous requests, reset wins
    fill(19, 23, 1'b1, 1'b1, 5'b00001);
    fill(24, 24, 1'b1, 1'b1, 5'b01111);
    fill(25, 25, 1'b1, 1'b1, 5'b00100);
    fill(26, 26, 1'b1, 1'b1, 5'b00000);
    fill(27, 30, 1'b0, 1'b0, 5'b00000);
    // back-to-back: rst edge lands during DRIVE_S
    fill(31, 32, 1'b1, 1'b0, 5'b00000);
    fill(33, 35, 1'b1, 1'b1, 5'b00000);
    fill(36, 36, 1'b1, 1'b1, 5'b10100);
    fill(37, 37, 1'b1, 1'b1, 5'b00101);
    fill(38, 38, 1'b1, 1'b1, 5'b00001);
    fill(39, 39, 1'b1, 1'b1, 5'b01101);
    fill(40, 40, 1'b1, 1'b1, 5'b00100);
    fill(41, 41, 1'b1, 1'b1, 5'b00000);

    clr = 1'b0; set_in = 1'b1; rst_in = 1'b0;
    clr2 = 1'b0; set2 = 1'b0; rst2 = 1'b0;

    // held in reset with set_in high
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("rst_hold", {1'b0, s, r, busy, q_model}, 5'b00000);
    end

    // release: s appears after the 6th edge
    clr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rel_e%0d", k), {4'b0, s}, {4'b0, k == 6});
    end

    // async clear mid-pulse on main instance, no edge needed
    #2;
    clr = 1'b0; set_in = 1'b0;
    #1;
    chk("async_clr", {s, r, busy, conflict, q_model}, 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    for (int i = 0; i < 41; i++) begin
      set_in = tbl[i].si;
      rst_in = tbl[i].ri;
      @(posedge clk); #1;
      chk($sformatf("vec_e%0d", i + 1),
          {s, r, busy, conflict, q_model}, tbl[i].exp);
    end

`ifdef SR_CMD_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL drop_cnt got %0d want 1", drop_cnt);
    end
`endif

    // mid-pulse reset with PULSE_LEN=4
    @(posedge clk); #1;
    set2 = 1'b1;
    clr2 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("p4_e%0d", k), {3'b0, s2, busy2},
          {3'b0, k >= 6, k >= 6});
    end
    #2;
    clr2 = 1'b0;
    #1;
    chk("p4_async", {1'b0, s2, r2, busy2, q2}, 5'b00000);
    set2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("p4_post%0d", k), {1'b0, s2, r2, busy2, q2},
          5'b00000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
